button_conditioner: RTL

//   Conditions one raw board push-button into clean one-cycle events for the
//   LED pattern sequencer, which sits directly downstream. One instance is used
//   per button (btn1, btn2). The block synchronises the pin, debounces press and

---
 rtl/button_conditioner.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchroniser, press/release debounce,
// long-press detection and auto-repeat, all emitted as registered one-cycle strobes.
module button_conditioner #(
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter int unsigned LONG_CYCLES     = 27000000,
    parameter int unsigned REPEAT_CYCLES   = 5400000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pressed_o,
    output logic press_pulse_o,
    output logic release_pulse_o,
    output logic long_pulse_o,
    output logic repeat_pulse_o
);

    localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HoldW = $clog2(LONG_CYCLES + 1);
    localparam int unsigned RepW  = (REPEAT_CYCLES == 0) ? 1 : $clog2(REPEAT_CYCLES + 1);

    localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);
    localparam logic [RepW-1:0]  RepLast  = RepW'(REPEAT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StDebPress,
        StPressed,
        StHeld,
        StDebRelease
    } state_e;

    state_e            state_q, state_d;
    logic              sync1_q, sync2_q;
    logic [DebW-1:0]   deb_cnt_q, deb_cnt_d;
    logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [RepW-1:0]   rep_cnt_q, rep_cnt_d;
    logic              from_held_q, from_held_d;
    logic              pressed_q, pressed_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;
    logic              raw_pressed;

    assign raw_pressed = sync2_q ^ ACTIVE_LOW;

    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        from_held_d = from_held_q;
        pressed_d   = pressed_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        repeat_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                pressed_d  = 1'b0;
                hold_cnt_d = '0;
                rep_cnt_d  = '0;
                if (raw_pressed) begin
                    // The idle-state sample is the first of the debounce run.
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d   = StPressed;
                        pressed_d = 1'b1;
                        press_d   = 1'b1;
                    end else begin
                        state_d   = StDebPress;
                        deb_cnt_d = DebW'(1);
                    end
                end
            end
            StDebPress: begin
                if (!raw_pressed) begin
                    state_d   = StIdle;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DebLast) begin
                    state_d    = StPressed;
                    deb_cnt_d  = '0;
                    hold_cnt_d = '0;
                    pressed_d  = 1'b1;
                    press_d    = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DebW'(1);
                end
            end
            StPressed, StHeld: begin
                if (!raw_pressed) begin
                    from_held_d = (state_q == StHeld);
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d   = StIdle;
                        pressed_d = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        state_d   = StDebRelease;
                        deb_cnt_d = DebW'(1);
                    end
                end else if (state_q == StPressed) begin
                    if (hold_cnt_q == HoldLast) begin
                        state_d    = StHeld;
                        hold_cnt_d = HoldW'(LONG_CYCLES);
                        rep_cnt_d  = '0;
                        long_d     = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HoldW'(1);
                    end
                end else if (REPEAT_CYCLES != 0) begin
                    if (rep_cnt_q == RepLast) begin
                        rep_cnt_d = '0;
                        repeat_d  = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + RepW'(1);
                    end
                end
            end
            StDebRelease: begin
                // Hold and repeat counters stay frozen so a bounce resumes timing.
                if (raw_pressed) begin
                    state_d   = from_held_q ? StHeld : StPressed;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DebLast) begin
                    state_d   = StIdle;
                    deb_cnt_d = '0;
                    pressed_d = 1'b0;
                    release_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DebW'(1);
                end
            end
            default: begin
                state_d   = StIdle;
                pressed_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q     <= ACTIVE_LOW;
            sync2_q     <= ACTIVE_LOW;
            state_q     <= StIdle;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            rep_cnt_q   <= '0;
            from_held_q <= 1'b0;
            pressed_q   <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            sync1_q     <= btn_i;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            from_held_q <= from_held_d;
            pressed_q   <= pressed_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
        end
    end

    assign pressed_o       = pressed_q;
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;
    assign long_pulse_o    = long_q;
    assign repeat_pulse_o  = repeat_q;

endmodule
